booth_multiplier_32_bit: RTL and testbench
==========================================

Name: booth_multiplier_32_bit

Overview:
Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit two's-complement product, one Booth iteration per clock. Sits directly upstream of and drives the team's 32-bit adder: every iteration's add/subtract of the multiplicand into the accumulator is performed by one adder_32_bit instance. Serves the ALU MUL path; start/busy/done handshake toward the controller.

Parameters:
WIDTH, 32, operand width; only 32 supported (matches adder_32_bit)
CNT_W, 6, iteration counter width (holds 0..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  32  multiplicand M (signed), captured when start accepted
b  input  32  multiplier Q (signed), captured when start accepted
busy  output  1  high while iterating (RUN)
done  output  1  one-cycle pulse: product valid
product  output  64  signed product; held until next accepted start or reset

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, busy=0, done=0, product=0, A=0, Q=0, q_m1=0, M=0, count=0. Reset wins over every other event, including mid-RUN; the in-flight operation is discarded, no done pulse.
- States: IDLE, RUN, DONE (encoded in package).
- IDLE: start=1 at edge N -> M<=a, Q<=b, A<=0, q_m1<=0, count<=0, state<=RUN. start=0 -> stay.
- RUN: busy=1. Each edge performs one iteration on {Q[0],q_m1}:
  - 00/11: no add; adder result ignored.
  - 01: S=A+M (adder b-input=M, c_in=0).
  - 10: S=A-M (adder b-input=~M, c_in=1).
  - Arithmetic shift right of {A,Q,q_m1} by 1. Bit shifted into A[31] is the true sign of the 33-bit result: sign = S[31] XOR ovf, ovf = (A[31]==Bop[31]) && (S[31]!=A[31]), Bop = M or ~M. For no-add cases, sign = A[31]. Adder c_out unused.
  - count<=count+1. The 32nd iteration (count==31) -> state<=DONE, product<={A,Q} after that shift.
- Timing: iterations at edges N+1..N+32; after edge N+32, done=1, busy=0, product valid. Total latency 32 cycles from start-accept edge to done.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally; start ignored in DONE.
- start while RUN/DONE: ignored, no queuing, operands not re-sampled.
- a/b changes after acceptance: no effect.
- product unchanged from DONE until next done (or reset); it is not cleared on a new start.
- Corner: a=b=0x80000000 handled via sign correction; result 0x4000000000000000.

Optional Feature:
Macro MULT_ZERO_BYPASS_EN.
- Defined: in IDLE with start=1 and (a==0 or b==0), edge N -> state<=DONE, product<=0; done=1 after edge N (1-cycle latency); busy never asserts.
- Undefined: zero operands take the normal 32-iteration path; result 0, done after edge N+32.

Decomposition:
- Package booth_mult_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2), WIDTH=32, CNT_W=6, ITERS=32.
- Sub-module: reuse existing adder_32_bit (one instance) for A+/-M; no new sub-module. Operand mux (M/~M) and c_in select are local logic.

Test Plan:
- Reset then a=7, b=-3 (0xFFFFFFFD), start pulse -> busy 32 cycles, done pulse after edge N+32, product=0xFFFFFFFF_FFFFFFEB.
- a=b=0x80000000 -> product=0x40000000_00000000; a=b=0x7FFFFFFF -> product=0x3FFFFFFF_00000001; a=0xFFFFFFFF, b=1 -> product=0xFFFFFFFF_FFFFFFFF.
- Start 5*6, then assert start with a=9, b=9 at cycle 10 of RUN -> ignored; done yields 30 (0x1E); product holds 30 until next accepted start.
- rst=1 at iteration 15 -> next cycle busy=0, done=0, product=0, state IDLE; no done pulse; new start 2*3 completes -> 6.
- Back-to-back: start held high continuously -> accepted in IDLE after each DONE; successive operations each take 32 RUN cycles + 1 DONE + 1 IDLE; products correct.
- a=0, b=12345: with MULT_ZERO_BYPASS_EN, done after edge N, product=0, busy never 1; without it, done after edge N+32, product=0.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Holds the operand/counter widths, the iteration count and the FSM
// state encoding used by the top and the bus interface.
package booth_mult_pkg;

    localparam int unsigned WIDTH = 32;  // operand width; only 32 supported
    localparam int unsigned CNT_W = 6;   // iteration counter width (0..32)
    localparam int unsigned ITERS = 32;  // Booth iterations per product

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/booth_multiplier_32_bit_if.sv
// Controller-side handshake bundle of the Booth multiplier.
//   start   : request, sampled only while the multiplier is idle
//   a, b    : multiplicand / multiplier (signed), captured on accept
//   busy    : high while iterating
//   done    : one-cycle pulse, product valid
//   product : signed 64-bit product, held until the next completion
// master = controller, slave = multiplier.
interface booth_multiplier_32_bit_if;
    import booth_mult_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/adder_32_bit.sv
// 32-bit ripple-style adder with carry in/out.
//   a_i, b_i : addends
//   c_i      : carry in
//   sum_o    : a_i + b_i + c_i (low 32 bits)
//   c_o      : carry out
module adder_32_bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] sum_o,
    output logic        c_o
);

    always_comb begin
        {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, c_i};
    end

endmodule

// File: rtl/booth_multiplier_32_bit.sv
// Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit product,
// one Booth iteration per clock (32 iterations per operation).
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : slave side of booth_multiplier_32_bit_if (start/a/b in,
//         busy/done/product out)
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand finishes in a
// single cycle with product 0 instead of running all iterations.
module booth_multiplier_32_bit
    import booth_mult_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    booth_multiplier_32_bit_if.slave  bus
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;     // Booth accumulator A
    logic [WIDTH-1:0]     mplr_q, mplr_d;   // multiplier register Q
    logic                 qm1_q, qm1_d;     // Q[-1]
    logic [WIDTH-1:0]     mcand_q, mcand_d; // multiplicand M
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [1:0]           booth_pair;
    logic                 do_add;
    logic                 do_sub;
    logic [WIDTH-1:0]     adder_b;
    logic [WIDTH-1:0]     adder_sum;
    logic                 adder_cout_unused;
    logic                 add_ovf;
    logic                 shift_sign;
    logic [WIDTH-1:0]     acc_pre;
    logic [WIDTH-1:0]     acc_shift;
    logic [WIDTH-1:0]     mplr_shift;
    logic                 last_iter;
    logic                 zero_bypass;

    assign booth_pair = {mplr_q[0], qm1_q};
    assign do_add     = (booth_pair == 2'b01);
    assign do_sub     = (booth_pair == 2'b10);
    assign adder_b    = do_sub ? ~mcand_q : mcand_q;

    adder_32_bit u_adder (
        .a_i   (acc_q),
        .b_i   (adder_b),
        .c_i   (do_sub),
        .sum_o (adder_sum),
        .c_o   (adder_cout_unused)
    );

    // The 32-bit sum can overflow (e.g. 0 - 0x80000000); the bit shifted
    // into A[31] must be the sign of the true 33-bit result.
    assign add_ovf    = (acc_q[WIDTH-1] == adder_b[WIDTH-1]) &&
                        (adder_sum[WIDTH-1] != acc_q[WIDTH-1]);
    assign acc_pre    = (do_add || do_sub) ? adder_sum : acc_q;
    assign shift_sign = (do_add || do_sub) ? (adder_sum[WIDTH-1] ^ add_ovf)
                                           : acc_q[WIDTH-1];
    assign acc_shift  = {shift_sign, acc_pre[WIDTH-1:1]};
    assign mplr_shift = {acc_pre[0], mplr_q[WIDTH-1:1]};
    assign last_iter  = (cnt_q == CNT_W'(ITERS - 1));

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_bypass = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        qm1_d     = qm1_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (zero_bypass) begin
                        state_d   = StDone;
                        product_d = '0;
                    end else begin
                        mcand_d = bus.a;
                        mplr_d  = bus.b;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                acc_d  = acc_shift;
                mplr_d = mplr_shift;
                qm1_d  = mplr_q[0];
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d   = StDone;
                    product_d = {acc_shift, mplr_shift};
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mplr_q    <= '0;
            qm1_q     <= 1'b0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            qm1_q     <= qm1_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_multiplier_32_bit.sv
// Self-checking bench for booth_multiplier_32_bit: directed corner cases
// plus random operands, compared against plain signed multiplication.
module tb_booth_multiplier_32_bit;
    import booth_mult_pkg::*;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_multiplier_32_bit_if bus ();

    booth_multiplier_32_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last_prod;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = 64'($signed(a));
        y = 64'($signed(b));
        return x * y;
    endfunction

    // One operation. inject_at: cycle of RUN at which a stray start (9*9)
    // is pulsed; reset_at: cycle at which rst is asserted (-1 = never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input int reset_at);
        int          lat;
        int          busy_cnt;
        logic [63:0] exp;
        bit          fast;
        exp  = ref_mul(a, b);
        fast = Bypass && ((a == 0) || (b == 0));
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            if (lat == 5) check_eq("prod_hold_run", bus.product, last_prod);
            if (lat == inject_at) begin
                bus.start = 1'b1;
                bus.a     = 32'd9;
                bus.b     = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (lat == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
                check_eq("rst_mid_done", 64'(bus.done), 64'd0);
                check_eq("rst_mid_prod", bus.product, 64'd0);
                @(negedge clk);
                check_eq("rst_mid_idle", 64'({bus.busy, bus.done}), 64'd0);
                last_prod = '0;
                return;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check_eq("done_seen", 64'(bus.done), 64'd1);
        check_eq("latency", 64'(lat), fast ? 64'd0 : 64'd32);
        check_eq("busy_cycles", 64'(busy_cnt), fast ? 64'd0 : 64'd32);
        check_eq("product", bus.product, exp);
        last_prod = exp;
        @(negedge clk);
        check_eq("done_pulse_end", 64'({bus.busy, bus.done}), 64'd0);
        check_eq("prod_hold_idle", bus.product, exp);
    endtask

    logic [31:0] ra, rb;
    logic [63:0] bexp;
    int          n;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        last_prod = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        check_eq("reset_prod", bus.product, 64'd0);
        rst = 1'b0;

        run_op(32'd7, 32'hFFFF_FFFD, -1, -1);
        run_op(32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1);
        run_op(32'hFFFF_FFFF, 32'd1, -1, -1);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, -1, -1);

        // Stray start mid-run is ignored; product then holds while idle.
        run_op(32'd5, 32'd6, 10, -1);
        repeat (3) @(negedge clk);
        check_eq("prod_hold_30", bus.product, 64'd30);

        run_op($urandom, $urandom, -1, 15);
        run_op(32'd2, 32'd3, -1, -1);

        run_op(32'd0, 32'd12345, -1, -1);
        run_op(32'd12345, 32'd0, -1, -1);

        // start held high: each op is accepted right after the IDLE cycle.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (ra == 0) ra = 32'd1;
            if (rb == 0) rb = 32'd1;
            bexp      = ref_mul(ra, rb);
            bus.start = 1'b1;
            bus.a     = ra;
            bus.b     = rb;
            n         = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.done && n < 100);
            check_eq("b2b_gap", 64'(n), (k == 0) ? 64'd33 : 64'd34);
            check_eq("b2b_product", bus.product, bexp);
        end
        bus.start = 1'b0;
        last_prod = bexp;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) ra = 32'h8000_0000;
            if (i % 7 == 2) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
